// File: rtl/scoreboard_ctrl.sv
// scoreboard_ctrl: CDC6600-style scoreboard sequencing NUM_FU units through issue, read-operands, execute, write-back.
// Define SCOREBOARD_PERF_EN to build the saturating issue-stall counter; otherwise stall_cnt is tied to zero.
module scoreboard_ctrl #(
    parameter int NUM_FU   = 5,
    parameter int NUM_REGS = 32,
    parameter int FU_W     = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic [FU_W-1:0]   issue_fu,
    input  logic              issue_we,
    input  logic [4:0]        issue_rd,
    input  logic [4:0]        issue_rs1,
    input  logic [4:0]        issue_rs2,
    output logic              issue_ready,
    output logic [NUM_FU-1:0] ro_grant,
    input  logic [NUM_FU-1:0] fu_done,
    output logic              wb_valid,
    output logic [FU_W-1:0]   wb_fu,
    output logic [4:0]        wb_rd,
    output logic [NUM_FU-1:0] fu_busy,
    output logic [31:0]       stall_cnt
);
    typedef enum logic [1:0] {IDLE, ISSUED, EXEC, DONE} state_t;
    state_t            st  [NUM_FU];
    logic [4:0]        fi  [NUM_FU];
    logic [4:0]        fj  [NUM_FU];
    logic [4:0]        fk  [NUM_FU];
    logic [FU_W-1:0]   qj  [NUM_FU];
    logic [FU_W-1:0]   qk  [NUM_FU];
    logic [FU_W-1:0]   rrs [NUM_REGS];
    logic [NUM_FU-1:0] rj, rk, elig;
    logic [FU_W-1:0]   src1_q, src2_q, wb_tag;
    logic              byp1, byp2, issue_go;

    always_comb begin
        for (int f = 0; f < NUM_FU; f++) begin
            fu_busy[f]  = st[f] != IDLE;
            ro_grant[f] = st[f] == ISSUED && rj[f] && rk[f];
            elig[f]     = st[f] == DONE;
            // x0 is never a WAR hazard, so non-writing units retire freely
            for (int g = 0; g < NUM_FU; g++)
                if (st[g] == ISSUED && fi[f] != '0 &&
                    ((fj[g] == fi[f] && rj[g]) || (fk[g] == fi[f] && rk[g])))
                    elig[f] = 1'b0;
        end
        wb_valid = |elig;
        wb_fu    = '0;
        for (int f = NUM_FU - 1; f >= 0; f--)
            if (elig[f]) wb_fu = FU_W'(f);
        wb_rd       = fi[wb_fu];
        wb_tag      = wb_fu + FU_W'(1);
        src1_q      = rrs[issue_rs1];
        src2_q      = rrs[issue_rs2];
        byp1        = wb_valid && src1_q == wb_tag;
        byp2        = wb_valid && src2_q == wb_tag;
        issue_ready = 32'(issue_fu) < NUM_FU && st[issue_fu] == IDLE &&
                      !(issue_we && issue_rd != '0 && rrs[issue_rd] != '0);
        issue_go    = issue_valid && issue_ready;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int f = 0; f < NUM_FU; f++) begin
                st[f] <= IDLE;
                fi[f] <= '0;
                fj[f] <= '0;
                fk[f] <= '0;
                qj[f] <= '0;
                qk[f] <= '0;
            end
            for (int r = 0; r < NUM_REGS; r++)
                rrs[r] <= '0;
            rj <= '0;
            rk <= '0;
        end else begin
            if (wb_valid && rrs[wb_rd] == wb_tag)
                rrs[wb_rd] <= '0;
            for (int f = 0; f < NUM_FU; f++) begin
                if (wb_valid && qj[f] == wb_tag) begin
                    rj[f] <= 1'b1;
                    qj[f] <= '0;
                end
                if (wb_valid && qk[f] == wb_tag) begin
                    rk[f] <= 1'b1;
                    qk[f] <= '0;
                end
                if (ro_grant[f]) begin
                    st[f] <= EXEC;
                    rj[f] <= 1'b0;
                    rk[f] <= 1'b0;
                end else if (st[f] == EXEC && fu_done[f]) begin
                    st[f] <= DONE;
                end else if (wb_valid && wb_fu == FU_W'(f)) begin
                    st[f] <= IDLE;
                end else if (issue_go && issue_fu == FU_W'(f)) begin
                    st[f] <= ISSUED;
                    fi[f] <= issue_we ? issue_rd : '0;
                    fj[f] <= issue_rs1;
                    fk[f] <= issue_rs2;
                    qj[f] <= byp1 ? '0 : src1_q;
                    qk[f] <= byp2 ? '0 : src2_q;
                    rj[f] <= src1_q == '0 || byp1;
                    rk[f] <= src2_q == '0 || byp2;
                end
            end
            if (issue_go && issue_we && issue_rd != '0)
                rrs[issue_rd] <= issue_fu + FU_W'(1);
        end
    end

`ifdef SCOREBOARD_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cnt <= '0;
        else if (issue_valid && !issue_ready && stall_cnt != '1)
            stall_cnt <= stall_cnt + 32'd1;
    end
`else
    assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_scoreboard_ctrl.sv
// tb_scoreboard_ctrl: vector table, directed hazard sequences and a random run against a
// per-instruction reference model of the scoreboard.
module tb_scoreboard_ctrl;
    localparam int NF = 5;
`ifdef SCOREBOARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          issue_valid = 1'b0, issue_we = 1'b0;
    logic [2:0]    issue_fu = '0;
    logic [4:0]    issue_rd = '0, issue_rs1 = '0, issue_rs2 = '0;
    logic [NF-1:0] fu_done = '0;
    logic          issue_ready, wb_valid;
    logic [NF-1:0] ro_grant, fu_busy;
    logic [2:0]    wb_fu;
    logic [4:0]    wb_rd;
    logic [31:0]   stall_cnt;
    int            checks = 0, fails = 0;

    always #5 clk = ~clk;

    scoreboard_ctrl dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_fu(issue_fu),
        .issue_we(issue_we), .issue_rd(issue_rd), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_ready(issue_ready), .ro_grant(ro_grant), .fu_done(fu_done),
        .wb_valid(wb_valid), .wb_fu(wb_fu), .wb_rd(wb_rd), .fu_busy(fu_busy), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input bit v, input int fu, input bit we, input int rd, input int r1,
                         input int r2, input logic [NF-1:0] done);
        issue_valid = v;
        issue_fu    = 3'(fu);
        issue_we    = we;
        issue_rd    = 5'(rd);
        issue_rs1   = 5'(r1);
        issue_rs2   = 5'(r2);
        fu_done     = done;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, '0);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, issue_ready, 1);
        chk({tag, "_grant"}, ro_grant, 0);
        chk({tag, "_wbv"}, wb_valid, 0);
        chk({tag, "_wbfu"}, wb_fu, 0);
        chk({tag, "_wbrd"}, wb_rd, 0);
        chk({tag, "_busy"}, fu_busy, 0);
        chk({tag, "_stall"}, stall_cnt, 0);
    endtask

    typedef struct {
        bit v; int fu; bit we; int rd, r1, r2; logic [NF-1:0] done;
        bit rdy; logic [NF-1:0] grant, busy; bit wbv; int wbfu, wbrd;
    } vec_t;
    vec_t tbl[16];

    // Reference model: one record per functional unit holding the instruction it owns.
    // ph 1 = waiting for operands, 2 = executing, 3 = finished; p1/p2 = producing unit or -1.
    typedef struct { bit act; int ph; int rd, rs1, rs2, p1, p2; } ent_t;
    ent_t m[NF];
    int   writer[32];
    int   m_stall;

    function automatic void m_reset();
        for (int i = 0; i < NF; i++) m[i] = '{0, 0, 0, 0, 0, -1, -1};
        for (int r = 0; r < 32; r++) writer[r] = -1;
        m_stall = 0;
    endfunction

    function automatic bit war_blocked(input int f);
        if (m[f].rd == 0) return 1'b0;
        for (int g = 0; g < NF; g++)
            if (m[g].act && m[g].ph == 1 &&
                ((m[g].rs1 == m[f].rd && m[g].p1 < 0) || (m[g].rs2 == m[f].rd && m[g].p2 < 0)))
                return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_cycle(input bit v, input int fu, input bit we, input int rd, input int r1,
                               input int r2, input logic [NF-1:0] done);
        logic [NF-1:0] e_grant, e_busy;
        bit e_rdy;
        int e_wb;
        e_grant = '0;
        e_busy  = '0;
        e_wb    = -1;
        for (int f = 0; f < NF; f++) begin
            e_busy[f]  = m[f].act;
            e_grant[f] = m[f].act && m[f].ph == 1 && m[f].p1 < 0 && m[f].p2 < 0;
        end
        for (int f = NF - 1; f >= 0; f--)
            if (m[f].act && m[f].ph == 3 && !war_blocked(f)) e_wb = f;
        e_rdy = !m[fu].act && !(we && rd != 0 && writer[rd] >= 0);
        chk("rnd_ready", issue_ready, e_rdy);
        chk("rnd_grant", ro_grant, e_grant);
        chk("rnd_busy", fu_busy, e_busy);
        chk("rnd_wbv", wb_valid, e_wb >= 0);
        if (e_wb >= 0) begin
            chk("rnd_wbfu", wb_fu, e_wb);
            chk("rnd_wbrd", wb_rd, m[e_wb].rd);
        end
        chk("rnd_stall", stall_cnt, PERF ? m_stall : 0);
        if (v && !e_rdy) m_stall++;
        if (e_wb >= 0) begin
            m[e_wb].act = 1'b0;
            if (writer[m[e_wb].rd] == e_wb) writer[m[e_wb].rd] = -1;
            for (int g = 0; g < NF; g++) begin
                if (m[g].p1 == e_wb) m[g].p1 = -1;
                if (m[g].p2 == e_wb) m[g].p2 = -1;
            end
        end
        for (int f = 0; f < NF; f++)
            if (e_grant[f]) m[f].ph = 2;
            else if (m[f].act && m[f].ph == 2 && done[f]) m[f].ph = 3;
        if (v && e_rdy) begin
            m[fu] = '{1, 1, we ? rd : 0, r1, r2, writer[r1], writer[r2]};
            if (we && rd != 0) writer[rd] = fu;
        end
    endtask

    initial begin
        tbl[0]  = '{1, 2, 1, 3, 1, 2, 5'h00, 1, 5'h00, 5'h00, 0, 0, 0};
        tbl[1]  = '{1, 0, 1, 4, 3, 1, 5'h00, 1, 5'h04, 5'h04, 0, 0, 0};
        tbl[2]  = '{0, 0, 0, 0, 0, 0, 5'h00, 0, 5'h00, 5'h05, 0, 0, 0};
        tbl[3]  = '{0, 0, 0, 0, 0, 0, 5'h04, 0, 5'h00, 5'h05, 0, 0, 0};
        tbl[4]  = '{0, 0, 0, 0, 0, 0, 5'h00, 0, 5'h00, 5'h05, 1, 2, 3};
        tbl[5]  = '{0, 0, 0, 0, 0, 0, 5'h00, 0, 5'h01, 5'h01, 0, 0, 0};
        tbl[6]  = '{0, 0, 0, 0, 0, 0, 5'h01, 0, 5'h00, 5'h01, 0, 0, 0};
        tbl[7]  = '{0, 0, 0, 0, 0, 0, 5'h00, 0, 5'h00, 5'h01, 1, 0, 4};
        tbl[8]  = '{0, 0, 0, 0, 0, 0, 5'h00, 1, 5'h00, 5'h00, 0, 0, 0};
        tbl[9]  = '{1, 1, 1, 9, 0, 0, 5'h00, 1, 5'h00, 5'h00, 0, 0, 0};
        tbl[10] = '{1, 3, 1, 10, 0, 0, 5'h00, 1, 5'h02, 5'h02, 0, 0, 0};
        tbl[11] = '{0, 0, 0, 0, 0, 0, 5'h00, 1, 5'h08, 5'h0A, 0, 0, 0};
        tbl[12] = '{0, 0, 0, 0, 0, 0, 5'h0A, 1, 5'h00, 5'h0A, 0, 0, 0};
        tbl[13] = '{0, 0, 0, 0, 0, 0, 5'h00, 1, 5'h00, 5'h0A, 1, 1, 9};
        tbl[14] = '{0, 0, 0, 0, 0, 0, 5'h00, 1, 5'h00, 5'h08, 1, 3, 10};
        tbl[15] = '{0, 0, 0, 0, 0, 0, 5'h00, 1, 5'h00, 5'h00, 0, 0, 0};

        #2;
        chk_reset_outputs("rst_init");
        step();
        rst = 1'b1;
        step();

        // RAW chain followed by two units finishing together
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].v, tbl[i].fu, tbl[i].we, tbl[i].rd, tbl[i].r1, tbl[i].r2, tbl[i].done);
            chk($sformatf("tbl%0d_ready", i), issue_ready, tbl[i].rdy);
            chk($sformatf("tbl%0d_grant", i), ro_grant, tbl[i].grant);
            chk($sformatf("tbl%0d_busy", i), fu_busy, tbl[i].busy);
            chk($sformatf("tbl%0d_wbv", i), wb_valid, tbl[i].wbv);
            if (tbl[i].wbv) begin
                chk($sformatf("tbl%0d_wbfu", i), wb_fu, tbl[i].wbfu);
                chk($sformatf("tbl%0d_wbrd", i), wb_rd, tbl[i].wbrd);
            end
            step();
        end

        // WAW and structural stalls behind DIV x5
        do_reset();
        drive(1, 3, 1, 5, 0, 0, '0);
        chk("waw_div_ready", issue_ready, 1);
        step();
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 1, 5, 1, 2, '0);
            chk("waw_ready", issue_ready, 0);
            step();
        end
        idle();
        chk("perf_stall4", stall_cnt, PERF ? 4 : 0);
        drive(1, 3, 1, 11, 0, 0, '0);
        chk("struct_ready", issue_ready, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 5'h08);
        step();
        drive(1, 0, 1, 5, 1, 2, '0);
        chk("waw_wbv", wb_valid, 1);
        chk("waw_wbrd", wb_rd, 5);
        chk("waw_ready_at_wb", issue_ready, 0);
        step();
        chk("waw_ready_after_wb", issue_ready, 1);
        step();
        idle();
        chk("perf_stall6", stall_cnt, PERF ? 6 : 0);

        // WAR: MUL x7 must wait until ALU add x6,x7,x8 has read x7
        do_reset();
        drive(1, 3, 1, 8, 0, 0, '0);
        step();
        drive(1, 0, 1, 6, 7, 8, '0);
        step();
        drive(1, 2, 1, 7, 0, 0, '0);
        chk("war_mul_ready", issue_ready, 1);
        step();
        idle();
        chk("war_mul_grant", ro_grant, 5'h04);
        step();
        drive(0, 0, 0, 0, 0, 0, 5'h04);
        step();
        for (int i = 0; i < 2; i++) begin
            idle();
            chk("war_hold_wbv", wb_valid, 0);
            chk("war_hold_grant", ro_grant, 0);
            step();
        end
        drive(0, 0, 0, 0, 0, 0, 5'h08);
        step();
        idle();
        chk("war_div_wbv", wb_valid, 1);
        chk("war_div_wbfu", wb_fu, 3);
        chk("war_div_wbrd", wb_rd, 8);
        step();
        chk("war_alu_grant", ro_grant, 5'h01);
        chk("war_still_held", wb_valid, 0);
        step();
        chk("war_mul_wbv", wb_valid, 1);
        chk("war_mul_wbfu", wb_fu, 2);
        chk("war_mul_wbrd", wb_rd, 7);
        step();

        // Random traffic with a mid-flight reset
        do_reset();
        m_reset();
        for (int c = 0; c < 3000; c++) begin
            bit v, we;
            int fu, rd, r1, r2;
            logic [NF-1:0] done;
            if (c == 1500) begin
                idle();
                rst = 1'b0;
                #1;
                chk_reset_outputs("rst_mid");
                step();
                rst = 1'b1;
                m_reset();
                for (int k = 0; k < 3; k++) begin
                    drive(0, 0, 0, 0, 0, 0, '1);
                    chk("rst_no_wb", wb_valid, 0);
                    chk("rst_no_busy", fu_busy, 0);
                    step();
                end
            end
            v    = ($urandom_range(0, 3) != 0);
            fu   = $urandom_range(0, NF - 1);
            we   = ($urandom_range(0, 4) != 0);
            rd   = $urandom_range(0, 7);
            r1   = $urandom_range(0, 7);
            r2   = $urandom_range(0, 7);
            done = NF'($urandom);
            drive(v, fu, we, rd, r1, r2, done);
            model_cycle(v, fu, we, rd, r1, r2, done);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
